// File: rtl/perf_counter_bank.sv
// Parametrised bank of event counters gated by a RUN/HALT state machine,
// with snapshot shadows, sticky overflow flags and a selectable readout.
module perf_counter_bank #(
    parameter int WIDTH    = 32,
    parameter int N_CH     = 4,
    parameter int SATURATE = 0,
    parameter int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [N_CH-1:0]  i_ev,
    input  logic             i_halt_req,
    input  logic             i_go,
    input  logic             i_sw_clear,
    input  logic             i_snap,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_rd_live,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [N_CH-1:0]  o_ovf,
    output logic             o_running
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_live   [N_CH];
    logic [WIDTH-1:0] r_shadow [N_CH];
    logic [N_CH-1:0]  r_ovf;
    logic [WIDTH-1:0] w_live_next [N_CH];
    logic [N_CH-1:0]  w_ovf_next;
    logic [WIDTH-1:0] w_rd_data;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others (snap relies on it).
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Go wins over a simultaneous halt request.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (i_halt_req && !i_go) w_state_next = ST_HALT;
            ST_HALT: if (i_go)                w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end

    // NOTE: defaults are assigned first so no path leaves an output unassigned
    // and no latch is inferred.
    always_comb begin
        w_ovf_next = r_ovf;
        for (int c = 0; c < N_CH; c++) begin
            w_live_next[c] = r_live[c];
            if (i_sw_clear) begin
                w_live_next[c] = '0;
                w_ovf_next[c]  = 1'b0;
            end else if (r_state == ST_RUN && i_ev[c]) begin
                if (&r_live[c]) begin
                    w_ovf_next[c]  = 1'b1;
                    w_live_next[c] = (SATURATE != 0) ? r_live[c] : '0;
                end else begin
                    w_live_next[c] = r_live[c] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_ovf <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_live[c]   <= '0;
                r_shadow[c] <= '0;
            end
        end else begin
            r_ovf <= w_ovf_next;
            for (int c = 0; c < N_CH; c++) begin
                r_live[c] <= w_live_next[c];
                if (i_snap) r_shadow[c] <= r_live[c];
            end
        end
    end

    // Unmatched selects (sel >= N_CH) fall through to zero.
    always_comb begin
        w_rd_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (i_sel == SEL_W'(c)) w_rd_data = i_rd_live ? r_live[c] : r_shadow[c];
        end
    end

    assign o_rd_data = w_rd_data;
    assign o_ovf     = r_ovf;
    assign o_running = (r_state == ST_RUN);

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised bank of event counters: the successor to the CPU's fixed three-counter cycle/branch/jump block. It counts up to N_CH independent event strobes from the single-cycle datapath, such as cycles, taken branches, jumps and memory writes. Counting is gated by a RUN/HALT state machine that tracks syscall halt and Go resume. The block also provides snapshot shadow registers, sticky overflow flags and a selectable readout for the LED/debug path.

## Interface
- WIDTH, 32, bit width of each counter and of rd_data (2..64)
- N_CH, 4, number of counter channels (1..16)
- SATURATE, 0, 0 = counters wrap modulo 2^WIDTH; 1 = counters stick at all-ones
- SEL_W, $clog2(N_CH) (min 1), width of sel

- clk  in  1  system clock; all state updates on rising edge
- clr  in  1  asynchronous, active-low reset (0 = reset asserted)
- ev  in  N_CH  per-channel event strobe; one count per cycle per asserted bit
- halt_req  in  1  halting syscall executing this cycle
- go  in  1  resume request (Go button, already synchronised)
- sw_clear  in  1  synchronous clear of all live counters and overflow flags
- snap  in  1  copy all live counters into shadow registers
- sel  in  SEL_W  channel selected for readout
- rd_live  in  1  1 = rd_data shows live counter; 0 = rd_data shows shadow
- rd_data  out  WIDTH  selected counter value
- ovf  out  N_CH  sticky per-channel overflow flags
- running  out  1  1 when the state machine is in RUN

## Operation
- State machine, two states:
  - RUN → HALT when halt_req=1 and go=0.
  - HALT → RUN when go=1.
  - Otherwise the state holds.
  - If halt_req=1 and go=1 arrive together in RUN, the state stays RUN (go wins).
- Counting: in RUN, live[i] increments by 1 on each edge where ev[i]=1. In HALT, ev is ignored.
  - Events in the same cycle as halt_req are counted, because that instruction still retires.
  - Events in the cycle go is sampled in HALT are not counted.
- Overflow: an increment from all-ones sets ovf[i]=1. The flag stays set until sw_clear or reset.
  - SATURATE=0: the counter goes to 0.
  - SATURATE=1: the counter stays at all-ones.
- sw_clear=1: all live counters and ovf go to 0 on that edge. It overrides any increment in the same cycle. It works in both states, does not change state, and does not touch the shadows.
- snap=1: shadow[i] takes live[i] as it was before this edge's increment or clear. It works in both states.
  - snap and sw_clear together: shadow gets the pre-clear values.
- Readout: rd_data is combinational. It is live[sel] if rd_live=1, else shadow[sel].
  - If sel ≥ N_CH, rd_data=0.
- Arithmetic is unsigned, WIDTH bits, with no carry out other than ovf.

## Timing
- Reset (clr=0, asynchronous): all live counters = 0, all shadows = 0, ovf = 0, state = RUN, running = 1, rd_data = 0.
- A counter update is visible on rd_data (live) immediately after the edge that samples ev. Latency is 1 edge, with no pipeline.
- A snap is visible on rd_data (shadow) after the sampling edge.
- running changes on the edge that samples halt_req or go.
- Asserting clr mid-count zeroes everything at once, with no wait for clk. Deassertion is synchronised externally. The first count after release is on the first rising edge with clr=1.
- go and halt_req are level-sampled each edge. A go held high for several cycles in HALT resumes once and then stays in RUN. A halt_req held high with go=0 keeps the block halted.

## Test plan
- Reset, then ev=4'b0001 for 10 cycles and ev=4'b0110 for 3 cycles, rd_live=1 → ch0=10, ch1=3, ch2=3, ch3=0, running=1.
- halt_req pulse with ev=4'b1111 in that cycle, then ev=4'b1111 for 5 cycles in HALT, then go pulse → every channel = 1 during HALT and running=0. After go, counting resumes the next cycle.
- WIDTH=8, SATURATE=0: 257 events on ch0 → ch0=1, ovf[0]=1. Then sw_clear → ch0=0, ovf=0. Repeat with SATURATE=1 → ch0=255, ovf[0]=1.
- Count ch2 to 7, then snap and sw_clear in the same cycle, then 2 more events → shadow ch2=7, live ch2=2.
- halt_req=1 and go=1 in the same cycle while in RUN → running stays 1 and that cycle's events are counted.
- clr driven low between edges mid-count → counters, shadows and ovf read 0 at once, running=1. sel=N_CH (N_CH=3, SEL_W=2) → rd_data=0.
